sdram_read_arb: RTL and testbench

SDRAM_READ_ARB -- requirements
Module: sdram_read_arb

---
 rtl/sdram_read_arb.sv | 177 +++++++++++++++++
 tb/tb_sdram_read_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arb.sv
// Round-robin arbiter that shares one Avalon-MM burst read port among N_REQ requesters.
// Each accepted request becomes one burst; returned beats are tagged with the owner's out_valid bit.
module sdram_read_arb #(
    parameter int SDRAM_W = 128,
    parameter int N_REQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*11-1:0]  req_cnt,
    input  logic [N_REQ-1:0]     req_start,
    output logic [N_REQ-1:0]     req_busy,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     out_valid,
    output logic [10:0]          out_idx,
    output logic [SDRAM_W-1:0]   out_data,
    output logic                 av_read,
    output logic [31:0]          av_address,
    output logic [10:0]          av_burstcount,
    input  logic [SDRAM_W-1:0]   av_readdata,
    input  logic                 av_readdatavalid,
    input  logic                 av_waitrequest
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     pending_q, pending_d;
    logic [31:0]          addr_q [N_REQ];
    logic [31:0]          addr_d [N_REQ];
    logic [10:0]          cnt_q [N_REQ];
    logic [10:0]          cnt_d [N_REQ];
    logic [31:0]          act_addr_q, act_addr_d;
    logic [10:0]          act_cnt_q, act_cnt_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        gnt_q, gnt_d;
    logic [10:0]          beat_q, beat_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [N_REQ-1:0]     out_valid_q, out_valid_d;
    logic [10:0]          out_idx_q, out_idx_d;
    logic [SDRAM_W-1:0]   out_data_q, out_data_d;

    logic                 found;
    logic [IW-1:0]        sel;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            act_addr_q  <= '0;
            act_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            beat_q      <= '0;
            done_q      <= '0;
            out_valid_q <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            act_addr_q  <= act_addr_d;
            act_cnt_q   <= act_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= addr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && pending_q[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        act_addr_d  = act_addr_q;
        act_cnt_d   = act_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        beat_d      = beat_q;
        done_d      = '0;
        out_valid_d = '0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            addr_d[i] = addr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (req_start[i] && !req_busy[i]) begin
                pending_d[i] = 1'b1;
                addr_d[i]    = req_addr[32*i +: 32];
                cnt_d[i]     = req_cnt[11*i +: 11];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    pending_d[sel] = 1'b0;
                    act_addr_d     = addr_q[sel];
                    act_cnt_d      = cnt_q[sel];
                    gnt_d          = sel;
                    beat_d         = '0;
                    // A zero-length request completes without touching the bus.
                    if (cnt_q[sel] == 11'd0) begin
                        done_d[sel] = 1'b1;
                        rr_ptr_d    = next_ptr(sel);
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!av_waitrequest) state_d = DATA;
            end
            DATA: begin
                if (av_readdatavalid) begin
                    out_data_d         = av_readdata;
                    out_idx_d          = beat_q;
                    out_valid_d[gnt_q] = 1'b1;
                    beat_d             = beat_q + 11'd1;
                    if (beat_q == act_cnt_q - 11'd1) begin
                        done_d[gnt_q] = 1'b1;
                        state_d       = IDLE;
                        rr_ptr_d      = next_ptr(gnt_q);
                        beat_d        = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy stays high through the done pulse so a restart lands the cycle after it.
    always_comb begin
        av_read       = (state_q == ISSUE);
        av_address    = av_read ? act_addr_q : 32'd0;
        av_burstcount = av_read ? act_cnt_q : 11'd0;
        req_done      = done_q;
        out_valid     = out_valid_q;
        out_idx       = out_idx_q;
        out_data      = out_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            req_busy[i] = pending_q[i] | done_q[i] | ((state_q != IDLE) && (gnt_q == IW'(i)));
        end
    end

endmodule

// File: tb/tb_sdram_read_arb.sv
// Directed testbench for sdram_read_arb: single read, contention, waitrequest,
// gapped data, zero-length request, restart while busy and reset mid-burst.
module tb_sdram_read_arb;

    localparam int W = 128;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*32-1:0]  req_addr;
    logic [N*11-1:0]  req_cnt;
    logic [N-1:0]     req_start;
    logic [N-1:0]     req_busy;
    logic [N-1:0]     req_done;
    logic [N-1:0]     out_valid;
    logic [10:0]      out_idx;
    logic [W-1:0]     out_data;
    logic             av_read;
    logic [31:0]      av_address;
    logic [10:0]      av_burstcount;
    logic [W-1:0]     av_readdata;
    logic             av_readdatavalid;
    logic             av_waitrequest;

    int tests = 0;
    int fails = 0;

    sdram_read_arb #(.SDRAM_W(W), .N_REQ(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_addr         (req_addr),
        .req_cnt          (req_cnt),
        .req_start        (req_start),
        .req_busy         (req_busy),
        .req_done         (req_done),
        .out_valid        (out_valid),
        .out_idx          (out_idx),
        .out_data         (out_data),
        .av_read          (av_read),
        .av_address       (av_address),
        .av_burstcount    (av_burstcount),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .av_waitrequest   (av_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [10:0] c);
        req_addr[32*i +: 32] = a;
        req_cnt[11*i +: 11]  = c;
    endtask

    task automatic start_reqs(input logic [N-1:0] m, input logic [N-1:0] exp_busy);
        req_start = m;
        tick;
        req_start = '0;
        check("busy_after_start", 128'(req_busy), 128'(exp_busy));
        check("no_read_before_grant", 128'(av_read), 128'd0);
    endtask

    // Called at a negedge where the next edge grants requester g.
    task automatic run_burst(input int g, input logic [31:0] a, input int cnt, input int w,
                             input logic [15:0] pat, input int plen);
        int b;
        logic [127:0] d;
        logic [N-1:0] onehot;
        b = 0;
        onehot = '0;
        onehot[g] = 1'b1;
        av_waitrequest = 1'b1;
        tick;
        for (int c = 0; c <= w; c++) begin
            check("issue_av_read", 128'(av_read), 128'd1);
            check("issue_address", 128'(av_address), 128'(a));
            check("issue_burstcount", 128'(av_burstcount), 128'(cnt));
            check("issue_no_valid", 128'(out_valid), 128'd0);
            if (c == 1) begin
                set_req(g, 32'hDEAD0000, 11'd7);
                req_start = onehot;
            end else begin
                req_start = '0;
            end
            av_waitrequest   = (c < w);
            av_readdatavalid = 1'b1;
            av_readdata      = '1;
            tick;
        end
        req_start      = '0;
        av_waitrequest = 1'b0;
        check("read_dropped", 128'(av_read), 128'd0);
        check("no_valid_from_issue", 128'(out_valid), 128'd0);
        for (int k = 0; k < plen; k++) begin
            d = {a, 64'h0, 32'(k) + 32'h5A00};
            av_readdatavalid = pat[k];
            av_readdata      = d;
            tick;
            if (pat[k]) begin
                check("beat_valid", 128'(out_valid), 128'(onehot));
                check("beat_idx", 128'(out_idx), 128'(b));
                check("beat_data", out_data, d);
                check("beat_done", 128'(req_done), (b == cnt - 1) ? 128'(onehot) : 128'd0);
                b++;
            end else begin
                check("gap_no_valid", 128'(out_valid), 128'd0);
                check("gap_no_done", 128'(req_done), 128'd0);
            end
        end
        av_readdatavalid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        req_addr         = '0;
        req_cnt          = '0;
        req_start        = '0;
        av_readdata      = '0;
        av_readdatavalid = 1'b0;
        av_waitrequest   = 1'b0;
        repeat (3) tick;
        check("reset_busy", 128'(req_busy), 128'd0);
        check("reset_av_read", 128'(av_read), 128'd0);
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_done", 128'(req_done), 128'd0);
        rst = 1'b0;

        // Single read of 4 beats
        set_req(0, 32'h1000, 11'd4);
        start_reqs(4'b0001, 4'b0001);
        run_burst(0, 32'h1000, 4, 0, 16'h000F, 4);
        check("busy_in_done_cycle", 128'(req_busy), 128'b0001);
        tick;
        check("busy_cleared", 128'(req_busy), 128'd0);
        check("done_cleared", 128'(req_done), 128'd0);

        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Contention: three simultaneous starts, then 0 and 2 together
        set_req(0, 32'h100, 11'd2);
        set_req(1, 32'h200, 11'd2);
        set_req(2, 32'h300, 11'd2);
        start_reqs(4'b0111, 4'b0111);
        run_burst(0, 32'h100, 2, 0, 16'h0003, 2);
        check("busy_mid_contention", 128'(req_busy), 128'b0111);
        run_burst(1, 32'h200, 2, 0, 16'h0003, 2);
        run_burst(2, 32'h300, 2, 0, 16'h0003, 2);
        tick;
        set_req(0, 32'h400, 11'd2);
        set_req(2, 32'h600, 11'd2);
        start_reqs(4'b0101, 4'b0101);
        run_burst(0, 32'h400, 2, 0, 16'h0003, 2);
        run_burst(2, 32'h600, 2, 0, 16'h0003, 2);
        tick;

        // Waitrequest held 5 cycles, with a restart attempt during ISSUE
        set_req(1, 32'h000ABCD0, 11'd2);
        start_reqs(4'b0010, 4'b0010);
        run_burst(1, 32'h000ABCD0, 2, 5, 16'h0003, 2);
        tick;
        check("restart_ignored_busy", 128'(req_busy), 128'd0);

        // Gapped read data 1,0,0,1,1
        set_req(3, 32'h3000, 11'd3);
        start_reqs(4'b1000, 4'b1000);
        run_burst(3, 32'h3000, 3, 0, 16'b11001, 5);
        tick;
        check("gapped_done_clear", 128'(req_done), 128'd0);

        // Zero-length request, restart attempt while pending
        set_req(2, 32'h2000, 11'd0);
        req_start = 4'b0100;
        tick;
        set_req(2, 32'h2200, 11'd5);
        check("cnt0_busy", 128'(req_busy), 128'b0100);
        tick;
        req_start = '0;
        check("cnt0_done", 128'(req_done), 128'b0100);
        check("cnt0_no_read", 128'(av_read), 128'd0);
        tick;
        check("cnt0_done_end", 128'(req_done), 128'd0);
        check("cnt0_busy_end", 128'(req_busy), 128'd0);
        check("cnt0_no_read_end", 128'(av_read), 128'd0);

        // Reset after 2 of 8 beats
        set_req(0, 32'h8000, 11'd8);
        start_reqs(4'b0001, 4'b0001);
        run_burst(0, 32'h8000, 8, 0, 16'h0003, 2);
        rst = 1'b1;
        av_readdatavalid = 1'b1;
        tick;
        check("rst_av_read", 128'(av_read), 128'd0);
        check("rst_av_address", 128'(av_address), 128'd0);
        check("rst_burstcount", 128'(av_burstcount), 128'd0);
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_idx", 128'(out_idx), 128'd0);
        check("rst_data", out_data, 128'd0);
        check("rst_done", 128'(req_done), 128'd0);
        check("rst_busy", 128'(req_busy), 128'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("trailing_no_valid", 128'(out_valid), 128'd0);
            check("trailing_no_read", 128'(av_read), 128'd0);
        end
        av_readdatavalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
